// File: rtl/ppu_bg_fetch_ctrl.sv
// Background fetch sequencer: scanline dot counter, 8-dot NT/AT/PT fetch cycle,
// shift-register load/shift strobes and loopy scroll-increment pulses.
module ppu_bg_fetch_ctrl #(
  parameter int LINE_DOTS      = 341,
  parameter int PREFETCH_START = 321,
  parameter int PREFETCH_END   = 336
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en_i,
  input  logic        render_en_i,
  input  logic [4:0]  coarse_x_i,
  input  logic [4:0]  coarse_y_i,
  input  logic [1:0]  nt_sel_i,
  input  logic [2:0]  fine_y_i,
  input  logic        bg_table_i,
  input  logic [7:0]  vram_rdata_i,
  output logic [13:0] vram_addr_o,
  output logic        vram_rd_o,
  output logic [8:0]  dot_o,
  output logic        line_end_o,
  output logic        sr_shift_en_o,
  output logic        sr_load_o,
  output logic [7:0]  pt_lo_o,
  output logic [7:0]  pt_hi_o,
  output logic [1:0]  at_bits_o,
  output logic        inc_coarse_x_o,
  output logic        inc_y_o,
  output logic        copy_x_o
);

  localparam logic [8:0] LAST_DOT       = 9'(LINE_DOTS - 1);
  localparam logic [8:0] PF_START       = 9'(PREFETCH_START);
  localparam logic [8:0] PF_END         = 9'(PREFETCH_END);
  localparam logic [8:0] PF_SHIFT_FIRST = 9'(PREFETCH_START + 1);
  localparam logic [8:0] PF_LOAD_FIRST  = 9'(PREFETCH_START + 8);
  localparam logic [8:0] PF_LAST_P1     = 9'(PREFETCH_END + 1);

  logic [8:0]  dot_q, dot_d;
  logic [7:0]  nt_q, nt_d;
  logic [1:0]  at_q, at_d;
  logic [7:0]  lo_stage_q, lo_stage_d;
  logic [7:0]  pt_lo_q, pt_lo_d;
  logic [7:0]  pt_hi_q, pt_hi_d;
  logic [1:0]  at_bits_q, at_bits_d;
  logic [13:0] addr_q, addr_d;

  logic [2:0]  phase;
  logic [2:0]  at_shift;
  logic        in_win;
  logic        load_dot;
  logic        shift_dot;
  logic        act;
  logic        drive;
  logic [13:0] fetch_addr;

  // (dot-1) mod 8 only needs the low three bits of the dot.
  assign phase    = dot_q[2:0] - 3'd1;
  assign at_shift = {coarse_y_i[1], coarse_x_i[1], 1'b0};

  assign in_win    = ((dot_q >= 9'd1) && (dot_q <= 9'd256)) ||
                     ((dot_q >= PF_START) && (dot_q <= PF_END));
  assign load_dot  = (phase == 3'd0) &&
                     (((dot_q >= 9'd9) && (dot_q <= 9'd257)) ||
                      ((dot_q >= PF_LOAD_FIRST) && (dot_q <= PF_LAST_P1)));
  assign shift_dot = ((dot_q >= 9'd2) && (dot_q <= 9'd257)) ||
                     ((dot_q >= PF_SHIFT_FIRST) && (dot_q <= PF_LAST_P1));

  assign act   = pix_en_i & render_en_i;
  assign drive = render_en_i & in_win & ~phase[0];

  always_comb begin
    fetch_addr = {2'b10, nt_sel_i, coarse_y_i, coarse_x_i};
    case (phase[2:1])
      2'd1:    fetch_addr = {2'b10, nt_sel_i, 4'b1111, coarse_y_i[4:2], coarse_x_i[4:2]};
      2'd2:    fetch_addr = {1'b0, bg_table_i, nt_q, 1'b0, fine_y_i};
      2'd3:    fetch_addr = {1'b0, bg_table_i, nt_q, 1'b1, fine_y_i};
      default: fetch_addr = {2'b10, nt_sel_i, coarse_y_i, coarse_x_i};
    endcase
  end

  // Address is held through odd phases and outside the window so the read data
  // that arrives one dot later still pairs with the address that produced it.
  assign vram_addr_o = drive ? fetch_addr : addr_q;
  assign addr_d      = vram_addr_o;

  always_comb begin
    dot_d      = dot_q;
    nt_d       = nt_q;
    at_d       = at_q;
    lo_stage_d = lo_stage_q;
    pt_lo_d    = pt_lo_q;
    pt_hi_d    = pt_hi_q;
    at_bits_d  = at_bits_q;
    if (pix_en_i) begin
      dot_d = (dot_q == LAST_DOT) ? 9'd0 : dot_q + 9'd1;
    end
    if (act && in_win) begin
      case (phase)
        3'd1: nt_d       = vram_rdata_i;
        3'd3: at_d       = vram_rdata_i[at_shift +: 2];
        3'd5: lo_stage_d = vram_rdata_i;
        3'd7: begin
          // Output bytes change on the edge that enters the load dot.
          pt_lo_d   = lo_stage_q;
          pt_hi_d   = vram_rdata_i;
          at_bits_d = at_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dot_q      <= '0;
      nt_q       <= '0;
      at_q       <= '0;
      lo_stage_q <= '0;
      pt_lo_q    <= '0;
      pt_hi_q    <= '0;
      at_bits_q  <= '0;
      addr_q     <= '0;
    end else begin
      dot_q      <= dot_d;
      nt_q       <= nt_d;
      at_q       <= at_d;
      lo_stage_q <= lo_stage_d;
      pt_lo_q    <= pt_lo_d;
      pt_hi_q    <= pt_hi_d;
      at_bits_q  <= at_bits_d;
      addr_q     <= addr_d;
    end
  end

  assign vram_rd_o      = drive;
  assign dot_o          = dot_q;
  assign line_end_o     = pix_en_i & (dot_q == LAST_DOT);
  assign sr_load_o      = act & load_dot;
  assign sr_shift_en_o  = act & shift_dot;
  assign inc_coarse_x_o = act & in_win & (phase == 3'd7);
  assign inc_y_o        = act & (dot_q == 9'd256);
  assign copy_x_o       = act & (dot_q == 9'd257);
  assign pt_lo_o        = pt_lo_q;
  assign pt_hi_o        = pt_hi_q;
  assign at_bits_o      = at_bits_q;

endmodule

// File: tb/tb_ppu_bg_fetch_ctrl.sv
// Bench for ppu_bg_fetch_ctrl: directed table, multi-cycle sequences and a
// randomized run checked against a dot-level behavioural model.
module tb_ppu_bg_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, pix_en, render_en, bg_table;
  logic [4:0]  coarse_x, coarse_y;
  logic [1:0]  nt_sel;
  logic [2:0]  fine_y;
  logic [7:0]  vram_rdata;
  logic [13:0] vram_addr;
  logic        vram_rd, line_end, sr_shift_en, sr_load, inc_coarse_x, inc_y, copy_x;
  logic [8:0]  dot;
  logic [7:0]  pt_lo, pt_hi;
  logic [1:0]  at_bits;

  logic [7:0]  nt_val, at_val, lo_val, hi_val;
  logic [13:0] rd_addr_q = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ppu_bg_fetch_ctrl dut (
    .clk(clk), .reset(reset), .pix_en_i(pix_en), .render_en_i(render_en),
    .coarse_x_i(coarse_x), .coarse_y_i(coarse_y), .nt_sel_i(nt_sel),
    .fine_y_i(fine_y), .bg_table_i(bg_table), .vram_rdata_i(vram_rdata),
    .vram_addr_o(vram_addr), .vram_rd_o(vram_rd), .dot_o(dot),
    .line_end_o(line_end), .sr_shift_en_o(sr_shift_en), .sr_load_o(sr_load),
    .pt_lo_o(pt_lo), .pt_hi_o(pt_hi), .at_bits_o(at_bits),
    .inc_coarse_x_o(inc_coarse_x), .inc_y_o(inc_y), .copy_x_o(copy_x)
  );

  // VRAM stand-in: one byte value per region, returned one dot after the address.
  function automatic logic [7:0] mem_pick(input logic [13:0] a, input logic [7:0] n,
                                          input logic [7:0] t, input logic [7:0] l,
                                          input logic [7:0] h);
    if (a[13:12] == 2'b10 && a[9:6] == 4'b1111) return t;
    else if (a[13]) return n;
    else if (!a[3]) return l;
    else return h;
  endfunction

  always @(posedge clk) if (pix_en) rd_addr_q <= vram_addr;
  assign vram_rdata = mem_pick(rd_addr_q, nt_val, at_val, lo_val, hi_val);

  // Reference model state
  int m_dot, m_nt, m_at, m_stage, m_lo, m_hi, m_atb, m_addr;
  logic [13:0] m_rd_addr = '0;
  int e_addr, e_rd, e_load, e_shift, e_incx, e_incy, e_copy, e_lend;

  int cnt_load, cnt_shift, cnt_incx, cnt_incy, cnt_copy, cnt_lend, cnt_rd;
  int dot_incy, dot_copy, dot_lend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (model dot %0d, t=%0t)",
                  name, act, exp, m_dot, $time);
  endtask

  task automatic model_reset();
    m_dot = 0; m_nt = 0; m_at = 0; m_stage = 0;
    m_lo = 0; m_hi = 0; m_atb = 0; m_addr = 0;
  endtask

  task automatic model_comb();
    int  d, ph, base;
    bit  win, act, drv;
    d    = m_dot;
    ph   = (d + 7) % 8;
    win  = (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
    act  = pix_en && render_en;
    drv  = render_en && win && (ph % 2 == 0);
    base = int'(bg_table) * 'h1000 + m_nt * 16 + int'(fine_y);
    e_addr = m_addr;
    if (drv) begin
      case (ph)
        0: e_addr = 'h2000 + int'(nt_sel) * 'h400 + int'(coarse_y) * 32 + int'(coarse_x);
        2: e_addr = 'h23C0 + int'(nt_sel) * 'h400 + (int'(coarse_y) / 4) * 8 + int'(coarse_x) / 4;
        4: e_addr = base;
        default: e_addr = base + 8;
      endcase
    end
    e_rd    = int'(drv);
    e_load  = int'(act && ((d >= 9 && d <= 257 && (d - 1) % 8 == 0) || d == 329 || d == 337));
    e_shift = int'(act && ((d >= 2 && d <= 257) || (d >= 322 && d <= 337)));
    e_incx  = int'(act && win && ph == 7);
    e_incy  = int'(act && d == 256);
    e_copy  = int'(act && d == 257);
    e_lend  = int'(pix_en && d == 340);
  endtask

  task automatic model_adv();
    int d, ph, rd, sh;
    d  = m_dot;
    ph = (d + 7) % 8;
    m_addr = e_addr;
    if (pix_en) begin
      rd = int'(mem_pick(m_rd_addr, nt_val, at_val, lo_val, hi_val));
      if (render_en && ((d >= 1 && d <= 256) || (d >= 321 && d <= 336))) begin
        case (ph)
          1: m_nt = rd;
          3: begin
            sh   = 2 * (2 * int'(coarse_y[1]) + int'(coarse_x[1]));
            m_at = (rd >> sh) & 3;
          end
          5: m_stage = rd;
          7: begin m_lo = m_stage; m_hi = rd; m_atb = m_at; end
          default: ;
        endcase
      end
      m_rd_addr = 14'(e_addr);
      m_dot = (d + 1) % 341;
    end
  endtask

  task automatic check_outputs();
    model_comb();
    chk("dot", 32'(dot), m_dot);
    chk("vram_addr", 32'(vram_addr), e_addr);
    chk("vram_rd", 32'(vram_rd), e_rd);
    chk("sr_load", 32'(sr_load), e_load);
    chk("sr_shift_en", 32'(sr_shift_en), e_shift);
    chk("inc_coarse_x", 32'(inc_coarse_x), e_incx);
    chk("inc_y", 32'(inc_y), e_incy);
    chk("copy_x", 32'(copy_x), e_copy);
    chk("line_end", 32'(line_end), e_lend);
    chk("pt_lo", 32'(pt_lo), m_lo);
    chk("pt_hi", 32'(pt_hi), m_hi);
    chk("at_bits", 32'(at_bits), m_atb);
  endtask

  task automatic clear_tally();
    cnt_load = 0; cnt_shift = 0; cnt_incx = 0; cnt_incy = 0;
    cnt_copy = 0; cnt_lend = 0; cnt_rd = 0;
    dot_incy = -1; dot_copy = -1; dot_lend = -1;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    cnt_load  += int'(sr_load);
    cnt_shift += int'(sr_shift_en);
    cnt_incx  += int'(inc_coarse_x);
    cnt_rd    += int'(vram_rd);
    if (inc_y)    begin cnt_incy++; dot_incy = int'(dot); end
    if (copy_x)   begin cnt_copy++; dot_copy = int'(dot); end
    if (line_end) begin cnt_lend++; dot_lend = int'(dot); end
    model_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    chk({tag, "_dot"}, 32'(dot), 0);
    chk({tag, "_addr"}, 32'(vram_addr), 0);
    chk({tag, "_rd"}, 32'(vram_rd), 0);
    chk({tag, "_strobes"}, 32'({sr_load, sr_shift_en, inc_coarse_x, inc_y, copy_x, line_end}), 0);
    chk({tag, "_pt"}, 32'({pt_hi, pt_lo, at_bits}), 0);
    pix_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  nts;
    logic [4:0]  cx, cy;
    logic [2:0]  fy;
    logic        bg;
    logic [7:0]  ntb, atb, lo, hi;
    logic [13:0] a0, a2, a4, a6;
    logic [1:0]  at;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{nts:2'd0, cx:5'd3,  cy:5'd5,  fy:3'd6, bg:1'b1, ntb:8'h42, atb:8'hE4,
                lo:8'hA5, hi:8'h3C, a0:14'h20A3, a2:14'h23C8, a4:14'h1426, a6:14'h142E, at:2'b01};
    vecs[1] = '{nts:2'd0, cx:5'd0,  cy:5'd2,  fy:3'd3, bg:1'b0, ntb:8'h10, atb:8'hE4,
                lo:8'h5A, hi:8'hC3, a0:14'h2040, a2:14'h23C0, a4:14'h0103, a6:14'h010B, at:2'b10};
    vecs[2] = '{nts:2'd3, cx:5'd31, cy:5'd26, fy:3'd7, bg:1'b1, ntb:8'hFF, atb:8'hC0,
                lo:8'h00, hi:8'hFF, a0:14'h2F5F, a2:14'h2FF7, a4:14'h1FF7, a6:14'h1FFF, at:2'b11};
    vecs[3] = '{nts:2'd1, cx:5'd4,  cy:5'd8,  fy:3'd0, bg:1'b0, ntb:8'h80, atb:8'hE4,
                lo:8'h01, hi:8'h80, a0:14'h2504, a2:14'h27D1, a4:14'h0800, a6:14'h0808, at:2'b00};

    reset = 1'b0; pix_en = 1'b0; render_en = 1'b0; bg_table = 1'b0;
    coarse_x = '0; coarse_y = '0; nt_sel = '0; fine_y = '0;
    nt_val = '0; at_val = '0; lo_val = '0; hi_val = '0;
    clear_tally();
    #1;
    do_reset("rst");

    // Table: one tile fetch per record, presented at dot 9
    for (int v = 0; v < 4; v++) begin
      do_reset("rst_vec");
      nt_sel = vecs[v].nts; coarse_x = vecs[v].cx; coarse_y = vecs[v].cy;
      fine_y = vecs[v].fy;  bg_table = vecs[v].bg;
      nt_val = vecs[v].ntb; at_val = vecs[v].atb; lo_val = vecs[v].lo; hi_val = vecs[v].hi;
      render_en = 1'b1; pix_en = 1'b1;
      for (int d = 0; d <= 9; d++) begin
        if (d == 1) chk("vec_ph0_addr", 32'(vram_addr), 32'(vecs[v].a0));
        if (d == 3) chk("vec_ph2_addr", 32'(vram_addr), 32'(vecs[v].a2));
        if (d == 5) chk("vec_ph4_addr", 32'(vram_addr), 32'(vecs[v].a4));
        if (d == 7) chk("vec_ph6_addr", 32'(vram_addr), 32'(vecs[v].a6));
        if (d == 9) begin
          chk("vec_load9", 32'(sr_load), 1);
          chk("vec_pt_lo", 32'(pt_lo), 32'(vecs[v].lo));
          chk("vec_pt_hi", 32'(pt_hi), 32'(vecs[v].hi));
          chk("vec_at_bits", 32'(at_bits), 32'(vecs[v].at));
        end
        if (d < 9) step();
      end
    end

    // One full scanline
    do_reset("rst_line");
    render_en = 1'b1; pix_en = 1'b1;
    clear_tally();
    for (int i = 0; i < 341; i++) step();
    chk("line_sr_load", cnt_load, 34);
    chk("line_inc_cx", cnt_incx, 34);
    chk("line_shift", cnt_shift, 272);
    chk("line_vram_rd", cnt_rd, 136);
    chk("line_inc_y", cnt_incy, 1);
    chk("line_inc_y_dot", dot_incy, 256);
    chk("line_copy_x", cnt_copy, 1);
    chk("line_copy_x_dot", dot_copy, 257);
    chk("line_end_cnt", cnt_lend, 1);
    chk("line_end_dot", dot_lend, 340);
    chk("line_wrap_dot", 32'(dot), 0);

    // render_en gap over dots 100..119
    do_reset("rst_gap");
    nt_sel = 2'd0; coarse_x = 5'd3; coarse_y = 5'd5;
    render_en = 1'b1; pix_en = 1'b1;
    for (int i = 0; i < 400 && m_dot != 100; i++) step();
    chk("gap_start_dot", 32'(dot), 100);
    render_en = 1'b0;
    clear_tally();
    for (int i = 0; i < 20; i++) step();
    chk("gap_strobes", cnt_load + cnt_shift + cnt_incx + cnt_incy + cnt_copy + cnt_rd, 0);
    chk("gap_end_dot", 32'(dot), 120);
    render_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("resume_dot_123", 32'(dot), 123);
    chk("resume_rd_123", 32'(vram_rd), 1);
    chk("resume_at_addr", 32'(vram_addr), 32'h23C8);
    for (int i = 0; i < 5; i++) step();
    chk("resume_incx_128", 32'(inc_coarse_x), 1);

    // Asynchronous reset in the middle of an active line
    for (int i = 0; i < 5; i++) step();
    do_reset("rst_mid");

    // Randomized run against the model
    render_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      pix_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) render_en = ~render_en;
      coarse_x = 5'($urandom); coarse_y = 5'($urandom);
      nt_sel   = 2'($urandom); fine_y   = 3'($urandom);
      bg_table = 1'($urandom);
      nt_val   = 8'($urandom); at_val   = 8'($urandom);
      lo_val   = 8'($urandom); hi_val   = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
